// File: rtl/if3_if.sv
// if3_if: groups the if3 upstream, downstream and instruction-bus signals.
// Latency: none; it only carries wires.
// Backpressure: valid/ready on both streams and stb/ack on the bus; the modports fix the direction of each.
interface if3_if;
    // upstream: translated address in
    logic        if3_valid_in;
    logic        if3_ready_out;
    logic [29:0] if3_paddr_in;
    // downstream: fetched word out to decode
    logic        if3_valid_out;
    logic        if3_ready_in;
    logic [31:0] if3_instr_out;
    logic [29:0] if3_paddr_out;
    logic [1:0]  if3_fault_out;
    // instruction memory bus
    logic        bus_stb;
    logic [27:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_data;

    // fetch-stage side
    modport slave (
        input  if3_valid_in, if3_paddr_in, if3_ready_in, bus_ack, bus_data,
        output if3_ready_out, if3_valid_out, if3_instr_out, if3_paddr_out,
               if3_fault_out, bus_stb, bus_addr
    );

    // environment side: address source, decode stage and memory
    modport master (
        output if3_valid_in, if3_paddr_in, if3_ready_in, bus_ack, bus_data,
        input  if3_ready_out, if3_valid_out, if3_instr_out, if3_paddr_out,
               if3_fault_out, bus_stb, bus_addr
    );
endinterface

// File: rtl/if3.sv
// if3: instruction fetch stage 3; one single-word bus read per aligned address, result buffered for decode.
// Latency: 2 cycles minimum from input transfer to valid output (ack in the first bus cycle).
// Backpressure: ready upstream only when idle or when the held result leaves this cycle; one bus read in flight.
// Optional macro IF3_TIMEOUT_EN: abort a read after TIMEOUT_CYCLES bus cycles without ack (fault 10).
module if3 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    if3_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
`ifdef IF3_TIMEOUT_EN
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
`endif

    state_t state;
    logic   take;
    logic   aligned;

    // Ready is combinational so a new address can enter on the same edge the held result leaves.
    assign io.if3_ready_out = (state == IDLE) | ((state == HOLD) & io.if3_ready_in);
    assign take             = io.if3_valid_in & io.if3_ready_out;
    assign aligned          = (io.if3_paddr_in[1:0] == 2'b00);

`ifdef IF3_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timed_out;
    // Last allowed bus cycle: without ack on this edge the read is abandoned.
    assign timed_out = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    // Fetch FSM with registered outputs; an accepted address overrides the HOLD->IDLE step so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            io.if3_valid_out <= 1'b0;
            io.if3_instr_out <= 32'h0;
            io.if3_paddr_out <= 30'h0;
            io.if3_fault_out <= FAULT_NONE;
            io.bus_stb       <= 1'b0;
            io.bus_addr      <= 28'h0;
`ifdef IF3_TIMEOUT_EN
            wait_cnt         <= 16'h0;
`endif
        end else begin
            case (state)
                BUS: begin
                    if (io.bus_ack) begin
                        io.if3_instr_out <= io.bus_data;
                        io.if3_fault_out <= FAULT_NONE;
                        io.bus_stb       <= 1'b0;
                        io.if3_valid_out <= 1'b1;
                        state            <= HOLD;
                    end
`ifdef IF3_TIMEOUT_EN
                    else if (timed_out) begin
                        io.if3_instr_out <= 32'h0;
                        io.if3_fault_out <= FAULT_TIMEOUT;
                        io.bus_stb       <= 1'b0;
                        io.if3_valid_out <= 1'b1;
                        state            <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                HOLD: begin
                    if (io.if3_ready_in) begin
                        io.if3_valid_out <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: ;
            endcase

            if (take) begin
                io.if3_paddr_out <= io.if3_paddr_in;
                if (aligned) begin
                    io.bus_addr      <= io.if3_paddr_in[29:2];
                    io.bus_stb       <= 1'b1;
                    io.if3_valid_out <= 1'b0;
                    state            <= BUS;
`ifdef IF3_TIMEOUT_EN
                    wait_cnt         <= 16'h0;
`endif
                end else begin
                    io.if3_instr_out <= 32'h0;
                    io.if3_fault_out <= FAULT_MISALIGN;
                    io.if3_valid_out <= 1'b1;
                    state            <= HOLD;
                end
            end
        end
    end

endmodule

// File: tb/tb_if3.sv
// tb_if3: directed bench for if3 with a response scoreboard and a simple memory model.
// Latency: n/a.
// Backpressure: the bench drives if3_ready_in directly and holds off decode where needed.
`timescale 1ns/1ps
module tb_if3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if3_if io();

`ifdef IF3_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    if3 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [29:0] paddr;
        logic [1:0]  fault;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    checks = 0;
    int    errors = 0;

    // memory model controls
    logic  ack_en    = 1'b1;
    int    ack_delay = 1;
    logic  force_ack = 1'b0;
    int    stb_cnt   = 0;

    function automatic resp_t mk(input logic [31:0] i, input logic [29:0] p, input logic [1:0] f);
        resp_t r;
        r.instr = i;
        r.paddr = p;
        r.fault = f;
        return r;
    endfunction

    function automatic logic [31:0] mem(input logic [27:0] wa);
        if (wa == 28'h400) return 32'hDEADBEEF;
        return {4'hC, wa};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an address until it is accepted; in_hold reports whether the DUT held a result at that moment.
    task automatic send(input logic [29:0] a, input logic push, input resp_t e, output logic in_hold);
        logic r;
        r = 1'b0;
        in_hold = 1'b0;
        if (push) exp_q.push_back(e);
        io.if3_valid_in = 1'b1;
        io.if3_paddr_in = a;
        for (int i = 0; i < 200 && !r; i++) begin
            @(negedge clk);
            r = io.if3_ready_out;
            in_hold = io.if3_valid_out;
            tick();
        end
        io.if3_valid_in = 1'b0;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL send_accept actual=not_accepted required=accepted addr=%0h", a);
        end
    endtask

    // Count bus_stb-high cycles over a fixed window.
    task automatic count_stb(input int window, output int n);
        n = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (io.bus_stb) n++;
            tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || io.if3_valid_out); i++) tick();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory model: ack after ack_delay extra stb cycles, or a forced ack when disabled.
    initial begin
        io.bus_ack  = 1'b0;
        io.bus_data = 32'h0;
        forever begin
            @(negedge clk);
            if (io.bus_stb) stb_cnt++;
            else stb_cnt = 0;
            if (ack_en) io.bus_ack = io.bus_stb && (stb_cnt == ack_delay + 1);
            else io.bus_ack = force_ack;
            io.bus_data = io.bus_ack ? mem(io.bus_addr) : 32'h0;
        end
    end

    // Scoreboard monitor: compare every output transfer against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && io.if3_valid_out && io.if3_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h/%0h/%0h required=none",
                             io.if3_instr_out, io.if3_paddr_out, io.if3_fault_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_instr", 64'(io.if3_instr_out), 64'(mon_e.instr));
                    check("out_paddr", 64'(io.if3_paddr_out), 64'(mon_e.paddr));
                    check("out_fault", 64'(io.if3_fault_out), 64'(mon_e.fault));
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic h;
        int   n;
        logic seen;

        rst = 1'b1;
        io.if3_valid_in = 1'b0;
        io.if3_paddr_in = 30'h0;
        io.if3_ready_in = 1'b1;
        ack_en    = 1'b0;
        force_ack = 1'b1;

        // reset values, with a stale ack present
        repeat (2) tick();
        @(negedge clk);
        check("rst_valid_out", 64'(io.if3_valid_out), 64'd0);
        check("rst_bus_stb",   64'(io.bus_stb),       64'd0);
        check("rst_fault",     64'(io.if3_fault_out), 64'd0);
        check("rst_instr",     64'(io.if3_instr_out), 64'd0);
        check("rst_paddr",     64'(io.if3_paddr_out), 64'd0);
        check("rst_bus_addr",  64'(io.bus_addr),      64'd0);
        check("rst_ready_out", 64'(io.if3_ready_out), 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("stale_ack_valid", 64'(io.if3_valid_out), 64'd0);
        check("stale_ack_stb",   64'(io.bus_stb),       64'd0);
        check("stale_ack_ready", 64'(io.if3_ready_out), 64'd1);
        tick();
        force_ack = 1'b0;
        ack_en    = 1'b1;
        ack_delay = 1;

        // single fetch: ack one cycle after stb, result visible in the third cycle after the transfer cycle
        send(30'h1000, 1'b1, mk(32'hDEADBEEF, 30'h1000, 2'b00), h);
        @(negedge clk);
        check("t1_stb",      64'(io.bus_stb),       64'd1);
        check("t1_bus_addr", 64'(io.bus_addr),      64'h400);
        check("t1_valid_c1", 64'(io.if3_valid_out), 64'd0);
        check("t1_ready_c1", 64'(io.if3_ready_out), 64'd0);
        tick();
        @(negedge clk);
        check("t1_valid_c2", 64'(io.if3_valid_out), 64'd0);
        check("t1_stb_c2",   64'(io.bus_stb),       64'd1);
        tick();
        @(negedge clk);
        check("t1_valid_c3", 64'(io.if3_valid_out), 64'd1);
        check("t1_stb_c3",   64'(io.bus_stb),       64'd0);
        tick();
        @(negedge clk);
        check("t1_valid_after", 64'(io.if3_valid_out), 64'd0);
        check("t1_ready_idle",  64'(io.if3_ready_out), 64'd1);
        tick();

        // back-to-back: second and third addresses enter straight from HOLD
        send(30'h100, 1'b1, mk(32'hC0000040, 30'h100, 2'b00), h);
        check("b2b_first_from_idle", 64'(h), 64'd0);
        send(30'h104, 1'b1, mk(32'hC0000041, 30'h104, 2'b00), h);
        check("b2b_second_in_hold", 64'(h), 64'd1);
        send(30'h108, 1'b1, mk(32'hC0000042, 30'h108, 2'b00), h);
        check("b2b_third_in_hold", 64'(h), 64'd1);
        drain();

        // backpressure: decode stalls 5 cycles while a new address waits
        io.if3_ready_in = 1'b0;
        send(30'h200, 1'b1, mk(32'hC0000080, 30'h200, 2'b00), h);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = io.if3_valid_out;
            tick();
        end
        check("bp_valid_seen", 64'(seen), 64'd1);
        exp_q.push_back(mk(32'hC0000081, 30'h204, 2'b00));
        io.if3_valid_in = 1'b1;
        io.if3_paddr_in = 30'h204;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(io.if3_valid_out), 64'd1);
            check("bp_instr", 64'(io.if3_instr_out), 64'hC0000080);
            check("bp_paddr", 64'(io.if3_paddr_out), 64'h200);
            check("bp_fault", 64'(io.if3_fault_out), 64'd0);
            check("bp_ready", 64'(io.if3_ready_out), 64'd0);
            check("bp_stb",   64'(io.bus_stb),       64'd0);
            tick();
        end
        io.if3_ready_in = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(io.if3_ready_out), 64'd1);
        tick();
        io.if3_valid_in = 1'b0;
        @(negedge clk);
        check("bp_next_stb", 64'(io.bus_stb), 64'd1);
        check("bp_next_bus_addr", 64'(io.bus_addr), 64'h81);
        tick();
        drain();

        // misaligned: no bus access, fault 01 on the next cycle
        send(30'h1002, 1'b1, mk(32'h0, 30'h1002, 2'b01), h);
        @(negedge clk);
        check("mis_valid", 64'(io.if3_valid_out), 64'd1);
        check("mis_stb",   64'(io.bus_stb),       64'd0);
        check("mis_fault", 64'(io.if3_fault_out), 64'd1);
        tick();
        @(negedge clk);
        check("mis_stb_after",   64'(io.bus_stb),       64'd0);
        check("mis_valid_after", 64'(io.if3_valid_out), 64'd0);
        tick();
        drain();

        // reset during BUS, ack arrives the cycle after reset
        ack_en    = 1'b0;
        force_ack = 1'b0;
        send(30'h300, 1'b0, mk(32'h0, 30'h0, 2'b00), h);
        @(negedge clk);
        check("rbus_stb_before", 64'(io.bus_stb), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check("rbus_stb",   64'(io.bus_stb),       64'd0);
        check("rbus_valid", 64'(io.if3_valid_out), 64'd0);
        check("rbus_ready", 64'(io.if3_ready_out), 64'd1);
        tick();
        force_ack = 1'b0;
        @(negedge clk);
        check("rbus_ack_ignored_valid", 64'(io.if3_valid_out), 64'd0);
        check("rbus_ack_ignored_stb",   64'(io.bus_stb),       64'd0);
        check("rbus_ack_ignored_ready", 64'(io.if3_ready_out), 64'd1);
        tick();
        ack_en = 1'b1;

`ifdef IF3_TIMEOUT_EN
        // no ack: stb for exactly 4 cycles, then fault 10
        ack_en = 1'b0;
        send(30'h400, 1'b1, mk(32'h0, 30'h400, 2'b10), h);
        count_stb(12, n);
        check("to_stb_cycles", 64'(n), 64'd4);
        drain();
        // ack in the 4th cycle wins over the timeout
        ack_en    = 1'b1;
        ack_delay = 3;
        send(30'h500, 1'b1, mk(32'hC0000140, 30'h500, 2'b00), h);
        count_stb(12, n);
        check("to_ack_last_stb_cycles", 64'(n), 64'd4);
        drain();
`else
        // without the timeout a slow ack still completes normally
        ack_delay = 6;
        send(30'h600, 1'b1, mk(32'hC0000180, 30'h600, 2'b00), h);
        count_stb(15, n);
        check("slow_ack_stb_cycles", 64'(n), 64'd7);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if3.md
Name: if3

Overview:
Instruction fetch stage 3 (memory access) is the downstream consumer of the address-translation stage's valid/ready output. It accepts a 30-bit physical instruction address and runs a single-word read on the instruction memory bus. It buffers the fetched word and presents it, with its address and a fault code, to the decode stage through a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles waited for bus_ack before a timeout fault; legal range 1..65535; used only with IF3_TIMEOUT_EN.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
if3_ready_out  output  1  stage can accept an address this cycle
if3_valid_in  input  1  if3_paddr_in is valid
if3_paddr_in  input  30  physical byte address of instruction
if3_ready_in  input  1  decode stage accepts output this cycle
if3_valid_out  output  1  output word/fault valid
if3_instr_out  output  32  fetched instruction word
if3_paddr_out  output  30  address belonging to if3_instr_out
if3_fault_out  output  2  00 none, 01 misaligned, 10 bus timeout, 11 unused
bus_stb  output  1  bus read request
bus_addr  output  28  word address = paddr[29:2]
bus_ack  input  1  bus read done; bus_data valid
bus_data  input  32  read data

Behaviour:
- Transfer rule: an input transfer occurs on an edge with if3_valid_in & if3_ready_out. An output transfer occurs on an edge with if3_valid_out & if3_ready_in.
- FSM states: IDLE, BUS, HOLD. Reset state is IDLE.
- Reset values: if3_valid_out=0, bus_stb=0, if3_fault_out=00, if3_instr_out=0, if3_paddr_out=0, bus_addr=0.
- if3_ready_out = (state==IDLE) | (state==HOLD & if3_ready_in). This is combinational and permits back-to-back fetches.
- Input transfer with paddr[1:0]==00:
  - latch paddr into if3_paddr_out and bus_addr;
  - next state BUS; bus_stb=1 from the next cycle.
- Input transfer with paddr[1:0]!=00:
  - no bus access;
  - next state HOLD; instr_out=0, fault=01, valid_out=1 from the next cycle.
- BUS:
  - bus_stb and bus_addr stay stable until the edge where bus_ack=1 is sampled.
  - On that edge: bus_data is latched into if3_instr_out, fault=00, stb drops, valid_out=1, state becomes HOLD.
  - Minimum latency from input transfer to valid_out is 2 cycles (ack in the first BUS cycle).
  - if3_ready_out=0 throughout BUS.
- HOLD:
  - valid_out=1; instr/paddr/fault held stable until the output transfer.
  - Output transfer without a simultaneous input transfer: valid_out=0 next cycle, state becomes IDLE.
  - Output transfer with a simultaneous input transfer: the new address is processed as from IDLE, so the next state is BUS or HOLD with no idle bubble.
- bus_ack sampled in IDLE or HOLD is ignored, including a stale ack after reset.
- Reset mid-operation (any state): on the rst edge, stb drops, valid_out drops, state becomes IDLE; the in-flight fetch is discarded.
- Only one bus transaction is outstanding at a time; no pipelined requests.

Optional Feature:
IF3_TIMEOUT_EN
- Defined:
  - a 16-bit counter clears on BUS entry and increments each BUS cycle without ack;
  - when the counter reaches TIMEOUT_CYCLES-1 without ack, the next edge drops stb, sets instr_out=0 and fault=10, and enters HOLD;
  - ack on that same edge takes priority, giving normal completion.
- Undefined: no counter exists; BUS waits indefinitely; fault code 10 never occurs.

Test Plan:
- Single fetch: paddr=0x0000_1000, ack one cycle after stb with data 0xDEADBEEF -> bus_addr=0x000_0400; valid_out with instr=0xDEADBEEF, paddr=0x0000_1000, fault=00, 3 cycles after the input transfer.
- Back-to-back with decode always ready: paddrs 0x100, 0x104, 0x108, ack 1 cycle after each stb -> three outputs in order with no IDLE cycle between them, and ready_out high in each HOLD cycle.
- Backpressure: if3_ready_in=0 for 5 cycles in HOLD -> outputs stable, ready_out=0, and a second valid_in is not accepted until if3_ready_in=1.
- Misaligned: paddr=0x0000_1002 -> bus_stb never asserted; valid_out next cycle with fault=01, instr=0.
- Reset in BUS: rst pulsed while stb=1, ack arrives the cycle after reset -> stb=0, valid_out=0, ack ignored, state IDLE, ready_out=1.
- IF3_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> stb high for exactly 4 cycles, then valid_out with fault=10, instr=0; with ack in the 4th cycle, normal completion instead.
